// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the round-robin RAM arbiter.
// Optional build macro: ARB_TIMEOUT_EN (bounded WAIT with forced error response).
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_TIMEOUT    = 15;

endpackage

// File: rtl/ram_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request strictly after
// last_grant, wrapping modulo NUM_REQ.
module rr_pick
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        // k = NUM_REQ revisits last_grant itself, so a lone requester keeps winning.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant) + k) % NUM_REQ;
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = IDX_W'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Round-robin sequencer sharing one single-port RAM among NUM_REQ requesters.
// Optional build macro: ARB_TIMEOUT_EN bounds WAIT to TIMEOUT cycles.
module ram_rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_error,
    output logic                          ram_en,
    output logic                          ram_valid,
    output logic                          ram_wr_rd,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_din,
    input  logic [DATA_WIDTH-1:0]         ram_dout,
    input  logic                          ram_ready,
    input  logic                          ram_error,
    output logic [1:0]                    arb_state
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("ram_rr_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
    end

    // Handshake: a request transfers on the rising edge where req_valid[i] and
    // req_ready[i] are both high; req_ready is one-hot and only ever high in IDLE.

    arb_state_t             state;
    logic [IDX_W-1:0]       last_grant;
    logic [NUM_REQ-1:0]     pick_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   sel_wr;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic [NUM_REQ-1:0]     grant_oh;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]       wait_cnt;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .idx        (pick_idx),
        .any        (pick_any)
    );

    assign req_ready = (state == IDLE) ? pick_grant : '0;
    assign grant_oh  = NUM_REQ'(1) << last_grant;
    assign arb_state = state;

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_wr    = req_wr[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_REQ - 1);
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_error  <= 1'b0;
            ram_en     <= 1'b0;
            ram_valid  <= 1'b0;
            ram_wr_rd  <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
`ifdef ARB_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            rsp_valid <= '0;
            unique case (state)
                IDLE: begin
                    ram_en    <= 1'b0;
                    ram_valid <= 1'b0;
                    if (pick_any) begin
                        ram_en     <= 1'b1;
                        ram_valid  <= 1'b1;
                        ram_wr_rd  <= sel_wr;
                        ram_addr   <= sel_addr;
                        ram_din    <= sel_wdata;
                        last_grant <= pick_idx;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_en    <= 1'b1;
                    ram_valid <= 1'b0;
                    state     <= WAIT;
`ifdef ARB_TIMEOUT_EN
                    wait_cnt  <= '0;
`endif
                end
                WAIT: begin
                    if (ram_ready) begin
                        rsp_valid <= grant_oh;
                        // Writes and failed accesses never return RAM data.
                        rsp_rdata <= (ram_wr_rd || ram_error) ? '0 : ram_dout;
                        rsp_error <= ram_error;
                        ram_en    <= 1'b0;
                        state     <= IDLE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_valid <= grant_oh;
                        rsp_rdata <= '0;
                        rsp_error <= 1'b1;
                        ram_en    <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Bench for ram_rr_arbiter: behavioural RAM stub, transaction-level reference
// model, directed vector table, hand sequences and randomized traffic.
module tb_ram_rr_arbiter;

    localparam int NUM_REQ = 2;
    localparam int AW      = 5;
    localparam int DW      = 32;
    localparam int TIMEOUT = 15;
    localparam int EXP_W   = 3 + 1 + DW;

    logic                   clk;
    logic                   rstn;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ-1:0]     req_wr;
    logic [NUM_REQ*AW-1:0]  req_addr;
    logic [NUM_REQ*DW-1:0]  req_wdata;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [DW-1:0]          rsp_rdata;
    logic                   rsp_error;
    logic                   ram_en;
    logic                   ram_valid;
    logic                   ram_wr_rd;
    logic [AW-1:0]          ram_addr;
    logic [DW-1:0]          ram_din;
    logic [DW-1:0]          ram_dout;
    logic                   ram_ready;
    logic                   ram_error;
    logic [1:0]             arb_state;

    int checks = 0;
    int errors = 0;

    ram_rr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .ram_en    (ram_en),
        .ram_valid (ram_valid),
        .ram_wr_rd (ram_wr_rd),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .ram_ready (ram_ready),
        .ram_error (ram_error),
        .arb_state (arb_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- RAM stub ----------------
    logic          hold_ready  = 1'b0;
    logic          inject_err  = 1'b0;
    logic          stub_pend;
    logic [DW-1:0] mem [0:31];

    always @(posedge clk) begin
        if (!rstn) begin
            for (int a = 0; a < 32; a++) mem[a] <= '0;
            ram_ready <= 1'b0;
            ram_error <= 1'b0;
            ram_dout  <= '0;
            stub_pend <= 1'b0;
        end else begin
            ram_ready <= 1'b0;
            if ((ram_en && ram_valid) || stub_pend) begin
                if (hold_ready) begin
                    stub_pend <= 1'b1;
                end else begin
                    stub_pend <= 1'b0;
                    ram_ready <= 1'b1;
                    if (inject_err) begin
                        ram_error <= 1'b1;
                        ram_dout  <= 32'hBAD0_BAD0;
                    end else begin
                        ram_error <= 1'b0;
                        ram_dout  <= mem[ram_addr];
                        if (ram_wr_rd) mem[ram_addr] <= ram_din;
                    end
                end
            end
            if (!ram_en) stub_pend <= 1'b0;
        end
    end

    // ---------------- reference model / scoreboard ----------------
    logic             model_on = 1'b1;
    logic [DW-1:0]    model_mem [0:31];
    int               model_last;
    int               busy;
    int               rsp_cd;
    int               w;
    int               c;
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] e;
    logic [DW-1:0]    held_rdata;
    logic             held_err;
    logic [NUM_REQ-1:0] exp_ready;
    logic [NUM_REQ-1:0] oh;
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_rdata;
    logic             m_err;

    always @(negedge clk) begin
        if (!rstn) begin
            for (int a = 0; a < 32; a++) model_mem[a] = '0;
            model_last = NUM_REQ - 1;
            busy       = 0;
            rsp_cd     = 0;
            held_rdata = '0;
            held_err   = 1'b0;
            exp_q.delete();
        end else if (model_on) begin
            if (rsp_cd > 0) rsp_cd--;
            if (exp_q.size() > 0 && rsp_cd == 0) begin
                e  = exp_q.pop_front();
                oh = '0;
                oh[e[EXP_W-1 -: 3]] = 1'b1;
                check("rsp_valid", rsp_valid, oh);
                check("rsp_rdata", rsp_rdata, e[DW-1:0]);
                check("rsp_error", rsp_error, e[DW]);
                held_rdata = e[DW-1:0];
                held_err   = e[DW];
            end else begin
                check("rsp_quiet", rsp_valid, 0);
                check("rsp_hold", {rsp_error, rsp_rdata}, {held_err, held_rdata});
            end

            exp_ready = '0;
            w = -1;
            if (busy > 0) begin
                busy--;
            end else begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    c = (model_last + k) % NUM_REQ;
                    if (w < 0 && req_valid[c]) w = c;
                end
                if (w >= 0) exp_ready[w] = 1'b1;
            end
            check("req_ready", req_ready, exp_ready);

            if (w >= 0) begin
                m_addr = req_addr[w*AW +: AW];
                m_err  = inject_err;
                if (m_err || req_wr[w]) m_rdata = '0;
                else m_rdata = model_mem[m_addr];
                if (!m_err && req_wr[w]) model_mem[m_addr] = req_wdata[w*DW +: DW];
                exp_q.push_back({3'(w), m_err, m_rdata});
                rsp_cd     = 3;
                busy       = 2;
                model_last = w;
            end
        end
    end

    logic [NUM_REQ-1:0] acc_seen;
    always @(negedge clk) acc_seen = req_valid & req_ready;

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic v, input logic wr,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data);
        req_valid[i]         = v;
        req_wr[i]            = wr;
        req_addr[i*AW +: AW] = addr;
        req_wdata[i*DW +: DW] = data;
    endtask

    typedef struct {
        int            req;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          err;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic do_vec(input vec_t v);
        logic ok;
        logic [NUM_REQ-1:0] want;
        want = '0;
        want[v.req] = 1'b1;
        @(posedge clk); #1;
        set_req(v.req, 1'b1, v.wr, v.addr, v.data);
        inject_err = v.err;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (req_ready[v.req]) ok = 1'b1;
        end
        check("vec_accept", ok, 1);
        @(posedge clk); #1;
        set_req(v.req, 1'b0, 1'b0, '0, '0);
        check("vec_c1_strobe", {ram_en, ram_valid, ram_wr_rd}, {2'b11, v.wr});
        check("vec_c1_addr", ram_addr, v.addr);
        if (v.wr) check("vec_c1_din", ram_din, v.data);
        @(posedge clk); #1;
        check("vec_c2_strobe", {ram_en, ram_valid}, 2'b10);
        check("vec_c2_rsp", rsp_valid, 0);
        @(posedge clk); #1;
        check("vec_c3_valid", rsp_valid, want);
        check("vec_c3_rdata", rsp_rdata, v.exp_rdata);
        check("vec_c3_error", rsp_error, v.exp_err);
        check("vec_c3_state", arb_state, 0);
        inject_err = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    int  gidx [6];
    int  gcyc [6];
    int  ng;
    int  first_rsp;
    int  bad;
    logic seen;

    initial begin
        vecs[0] = '{0, 1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0};
        vecs[1] = '{1, 1'b0, 5'd5,  32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{0, 1'b1, 5'd9,  32'h1234_5678, 1'b0, 32'h0,         1'b0};
        vecs[3] = '{1, 1'b0, 5'd9,  32'h0,         1'b0, 32'h1234_5678, 1'b0};
        vecs[4] = '{1, 1'b1, 5'd5,  32'hCAFE_F00D, 1'b0, 32'h0,         1'b0};
        vecs[5] = '{0, 1'b0, 5'd5,  32'h0,         1'b0, 32'hCAFE_F00D, 1'b0};
        vecs[6] = '{0, 1'b0, 5'd7,  32'h0,         1'b1, 32'h0,         1'b1};
        vecs[7] = '{0, 1'b1, 5'd7,  32'h7777_7777, 1'b1, 32'h0,         1'b1};
        vecs[8] = '{1, 1'b0, 5'd7,  32'h0,         1'b0, 32'h0,         1'b0};

        rstn      = 1'b0;
        req_valid = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        check("reset_rsp", {rsp_valid, rsp_error, rsp_rdata}, 0);
        check("reset_ram", {ram_en, ram_valid, ram_wr_rd, ram_addr, ram_din}, 0);
        check("reset_state", arb_state, 0);
        check("reset_ready", req_ready, 0);

        // Directed table: write/read pairs, error passthrough, errored write.
        for (int i = 0; i < 9; i++) do_vec(vecs[i]);

        // Both requesters hold reads: grants must alternate every 3 cycles.
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 5'd5, '0);
        set_req(1, 1'b1, 1'b0, 5'd9, '0);
        ng = 0;
        for (int n = 0; n < 40 && ng < 6; n++) begin
            @(negedge clk);
            if (req_ready != 0) begin
                gidx[ng] = req_ready[1] ? 1 : 0;
                gcyc[ng] = cyc;
                ng++;
            end
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        check("b2b_count", ng, 6);
        for (int k = 0; k < ng; k++) begin
            check("b2b_grant", gidx[k], k % 2);
            if (k > 0) check("b2b_spacing", gcyc[k] - gcyc[k-1], 3);
        end
        repeat (4) @(posedge clk);

        // Randomized traffic, including withdrawn requests.
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && acc_seen[i]) begin
                    if ($urandom_range(1, 0) == 1)
                        set_req(i, 1'b1, 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), $urandom);
                    else
                        set_req(i, 1'b0, 1'b0, '0, '0);
                end else if (req_valid[i]) begin
                    if ($urandom_range(15, 0) == 0) set_req(i, 1'b0, 1'b0, '0, '0);
                end else if ($urandom_range(2, 0) == 0) begin
                    set_req(i, 1'b1, 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), $urandom);
                end
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (6) @(posedge clk);

        // Reset during ISSUE of a write to addr 3: abandoned, nothing written.
        model_on = 1'b0;
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b1, 5'd3, 32'h55AA_55AA);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (req_ready[0]) seen = 1'b1;
        end
        check("rst_accept", seen, 1);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        check("rst_in_issue", {arb_state, ram_valid}, {2'd1, 1'b1});
        rstn = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_rsp", {rsp_valid, rsp_error, rsp_rdata}, 0);
        check("rst_mid_ram", {ram_en, ram_valid, ram_wr_rd, ram_addr, ram_din}, 0);
        check("rst_mid_state", arb_state, 0);
        rstn = 1'b1;
        bad = 0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            if (rsp_valid != 0) bad++;
        end
        check("rst_no_rsp", bad, 0);
        model_on = 1'b1;
        do_vec('{0, 1'b0, 5'd3, 32'h0, 1'b0, 32'h0, 1'b0});
        repeat (2) @(posedge clk);

        // RAM never signals ready.
        model_on   = 1'b0;
        hold_ready = 1'b1;
        @(posedge clk); #1;
        set_req(1, 1'b1, 1'b0, 5'd9, '0);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (req_ready[1]) seen = 1'b1;
        end
        check("hold_accept", seen, 1);
        @(posedge clk); #1;
        set_req(1, 1'b0, 1'b0, '0, '0);
`ifdef ARB_TIMEOUT_EN
        first_rsp = -1;
        for (int n = 2; n < 40 && first_rsp < 0; n++) begin
            @(posedge clk); #1;
            if (rsp_valid != 0) begin
                first_rsp = n;
                check("tmo_valid", rsp_valid, 2'b10);
                check("tmo_error", rsp_error, 1);
                check("tmo_rdata", rsp_rdata, 0);
                check("tmo_state", arb_state, 0);
            end
        end
        check("tmo_cycle", first_rsp, 2 + TIMEOUT);
        hold_ready = 1'b0;
`else
        bad = 0;
        for (int n = 2; n < 22; n++) begin
            @(posedge clk); #1;
            if (rsp_valid != 0 || arb_state != 2'd2 || ram_en != 1'b1) bad++;
        end
        check("hold_waits", bad, 0);
        hold_ready = 1'b0;
        first_rsp = -1;
        for (int n = 0; n < 6 && first_rsp < 0; n++) begin
            @(posedge clk); #1;
            if (rsp_valid != 0) begin
                first_rsp = n;
                check("hold_valid", rsp_valid, 2'b10);
                check("hold_rdata", rsp_rdata, 0);
                check("hold_error", rsp_error, 0);
            end
        end
        check("hold_release", first_rsp, 1);
`endif
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
- Round-robin arbiter/sequencer sharing one single_port_ram_rtl instance (32x32) among NUM_REQ requesters.
- Accepts one request at a time and drives the RAM en/valid/wr_rd/addr/din strobe.
- Captures RAM dout/ready/error and returns a one-cycle response to the granted requester.
- Sits between the bus-side masters and the RAM.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 5, RAM address width.
- DATA_WIDTH, 32, RAM data width.
- TIMEOUT, 15, max WAIT cycles before forced error; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request strobe.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_wr  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data.
- rsp_valid  out  NUM_REQ  one-cycle response pulse, one-hot.
- rsp_rdata  out  DATA_WIDTH  read data, qualified by rsp_valid.
- rsp_error  out  1  error flag, qualified by rsp_valid.
- ram_en, ram_valid, ram_wr_rd  out  1  RAM controls.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_din  out  DATA_WIDTH  RAM write data.
- ram_dout  in  DATA_WIDTH  RAM read data.
- ram_ready, ram_error  in  1  RAM status.

Behaviour:
- Reset: state=IDLE; last_grant=NUM_REQ-1, so requester 0 wins first.
  - Registered outputs go to 0: rsp_valid, rsp_rdata, rsp_error, ram_en, ram_valid, ram_wr_rd, ram_addr, ram_din.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Winner = first asserted req_valid searching from last_grant+1 upward, with modulo-NUM_REQ wrap.
  - req_ready[winner]=1, combinational; only in IDLE.
  - On req_valid&req_ready: latch wr/addr/wdata into the ram_* registers, set last_grant=winner, go ISSUE.
  - No request: ram_en=0, ram_valid=0, stay IDLE.
- ISSUE: exactly one cycle with ram_en=1, ram_valid=1; go WAIT.
- WAIT:
  - ram_en=1, ram_valid=0; ram_addr/ram_din/ram_wr_rd held.
  - On ram_ready=1:
    - next cycle rsp_valid[last_grant]=1;
    - rsp_rdata=ram_dout on a read, 0 on a write;
    - rsp_error=ram_error;
    - go IDLE.
- Timing:
  - accept edge = cycle 0;
  - ram_valid during cycle 1;
  - ram_ready seen in cycle 2;
  - rsp_valid in cycle 3, coinciding with IDLE, so a new accept is possible in cycle 3.
  - Throughput is one transaction per 3 cycles.
- rsp_valid is a single-cycle pulse; rsp_rdata/rsp_error hold until the next response.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 transactions.
- req_valid deasserted before accept: no effect. Nothing is latched outside IDLE.
- Reset mid-transaction: abandon, no rsp_valid, return to IDLE. rstn also resets the RAM.
- RAM error (X/Z address/data): passed through as rsp_error=1, rsp_rdata=0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - 4-bit (clog2(TIMEOUT+1)) counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without ram_ready: rsp_valid[last_grant]=1, rsp_error=1, rsp_rdata=0, go IDLE.
- Undefined: WAIT holds indefinitely until ram_ready; no counter logic.

Decomposition:
- Package ram_arb_pkg holds:
  - state enum (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2);
  - default width constants ADDR_WIDTH=5, DATA_WIDTH=32;
  - TIMEOUT default.
- One sub-module: rr_pick.
  - Combinational round-robin selector.
  - Inputs: req vector, last_grant. Outputs: one-hot grant, index, any.

Test Plan:
- Reset, then requester 0 writes addr 5 = 0xDEADBEEF -> ram_valid pulses in cycle 1 with ram_wr_rd=1; rsp_valid[0] in cycle 3, rsp_error=0.
- Requester 1 reads addr 5 after the write above -> rsp_valid[1] pulse, rsp_rdata=0xDEADBEEF, rsp_error=0.
- Both requesters hold req_valid with 6 back-to-back reads -> grants alternate 0,1,0,1,0,1; accepts every 3 cycles.
- Requester 0 drives req_addr with X -> rsp_valid[0], rsp_error=1, rsp_rdata=0.
- rstn=0 during ISSUE of a write to addr 3 -> no rsp_valid; all outputs 0 next cycle; a later read of addr 3 returns 0.
- With ARB_TIMEOUT_EN: hold ram_ready=0 through an external stub -> rsp_error=1 exactly TIMEOUT=15 cycles after entering WAIT, then IDLE.
